pwm_capture: RTL and testbench

//  Receive-side counterpart of the PWM generator: measures an incoming PWM waveform.

---
 rtl/pwm_capture.sv | 76 +++++++
 tb/tb_pwm_capture.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an asynchronous PWM input
module pwm_capture #(
  parameter int N = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         pwm_in,
  output logic [N-1:0] period_out,
  output logic [N-1:0] high_out,
  output logic         valid,
  output logic         lost,
  output logic         level_out
);
  typedef enum logic [1:0] {IDLE, HIGH, LOW, LOST} state_t;
  localparam logic [N-1:0] MAX = '1;
  state_t state;
  logic [SYNC_STAGES-1:0] sync;
  logic p;
  logic [N-1:0] cnt, hi_lat;
  logic rise, fall, at_max;
  assign level_out = sync[SYNC_STAGES-1];
  assign rise = level_out & ~p;
  assign fall = ~level_out & p;
  assign at_max = cnt == MAX;
  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= '0;
      p <= 1'b0;
      cnt <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pwm_in};
      p <= level_out;
      cnt <= rise ? N'(1) : at_max ? cnt : cnt + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      hi_lat <= '0;
      period_out <= '0;
      high_out <= '0;
      valid <= 1'b0;
      lost <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: if (rise) state <= HIGH;
        HIGH:
          if (fall) begin
            state <= LOW;
            hi_lat <= cnt;
          end else if (at_max) begin
            state <= LOST;
            lost <= 1'b1;
          end
        LOW:
          if (rise) begin
            state <= HIGH;
            period_out <= cnt;
            high_out <= hi_lat;
            valid <= 1'b1;
          end else if (at_max) begin
            state <= LOST;
            lost <= 1'b1;
          end
        LOST:
          if (rise) begin
            state <= HIGH;
            lost <= 1'b0;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed PWM waveforms with a queue-based scoreboard on valid
module tb_pwm_capture;
  localparam int N = 10;
  logic clk = 1'b0;
  logic reset, pwm_in;
  logic [N-1:0] period_out, high_out;
  logic valid, lost, level_out;
  int total = 0;
  int bad = 0;
  logic [2*N-1:0] exp_q[$];
  logic pend;
  logic [N-1:0] pend_p, pend_h;

  pwm_capture #(.N(N), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .pwm_in(pwm_in),
    .period_out(period_out), .high_out(high_out),
    .valid(valid), .lost(lost), .level_out(level_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_period"}, period_out, 0);
    chk({name, "_high"}, high_out, 0);
    chk({name, "_valid"}, valid, 0);
    chk({name, "_lost"}, lost, 0);
    chk({name, "_level"}, level_out, 0);
  endtask

  task automatic rise_now();
    pwm_in = 1'b1;
    if (pend) exp_q.push_back({pend_p, pend_h});
  endtask

  task automatic burst(input int h, input int l, input int n);
    for (int i = 0; i < n; i++) begin
      rise_now();
      tick(h);
      pwm_in = 1'b0;
      tick(l);
      pend = 1'b1;
      pend_p = N'(h + l);
      pend_h = N'(h);
    end
  endtask

  always @(negedge clk) begin
    if (valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid period=%0d high=%0d exp=none", period_out, high_out);
      end else begin
        logic [2*N-1:0] e;
        e = exp_q.pop_front();
        chk("publish_period", period_out, e[2*N-1:N]);
        chk("publish_high", high_out, e[N-1:0]);
        chk("publish_lost", lost, 0);
      end
    end
  end

  initial begin
    reset = 1'b1;
    pwm_in = 1'b0;
    pend = 1'b0;
    pend_p = '0;
    pend_h = '0;
    tick(3);
    chk_zero("reset");
    reset = 1'b0;
    tick(2);
    burst(3, 5, 4);
    burst(1, 1, 6);
    chk("min_lost", lost, 0);
    rise_now();
    pend = 1'b0;
    tick(1025);
    chk("hold_lost_before", lost, 0);
    chk("hold_level", level_out, 1);
    tick(1);
    chk("hold_lost_after", lost, 1);
    chk("hold_period", period_out, 2);
    chk("hold_high", high_out, 1);
    tick(74);
    chk("hold_lost_end", lost, 1);
    pwm_in = 1'b0;
    tick(6);
    chk("lost_while_low", lost, 1);
    rise_now();
    tick(2);
    chk("lost_before_clear", lost, 1);
    tick(1);
    chk("lost_cleared", lost, 0);
    tick(1);
    pwm_in = 1'b0;
    tick(6);
    pend = 1'b1;
    pend_p = 10;
    pend_h = 4;
    burst(4, 6, 2);
    burst(3, 5, 2);
    rise_now();
    tick(3);
    pwm_in = 1'b0;
    reset = 1'b1;
    tick(1);
    chk_zero("midreset");
    reset = 1'b0;
    pend = 1'b0;
    tick(4);
    burst(3, 5, 3);
    burst(500, 523, 2);
    rise_now();
    tick(6);
    chk("max_period_lost", lost, 0);
    chk("max_period_out", period_out, 1023);
    chk("max_high_out", high_out, 500);
    pwm_in = 1'b0;
    tick(6);
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
